// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared types and helpers for the multi-port register file.
//   state_t     : init sequencer states (INIT while the array is being
//                 filled, RUN for normal operation)
//   byp_sel_t   : read-port source select (array, write port 0, write port 1)
//   INIT_ZERO / INIT_INDEX : values accepted by the INIT_MODE parameter
//   bypass_sel  : picks the read source from the two same-cycle write hits
package regfile_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        SEL_ARRAY,
        SEL_WR0,
        SEL_WR1
    } byp_sel_t;

    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;

    // Write port 0 outranks write port 1, matching the array write priority,
    // so a bypassed value always equals what the array will hold next cycle.
    function automatic byp_sel_t bypass_sel(input logic hit0, input logic hit1);
        if (hit0) begin
            return SEL_WR0;
        end
        if (hit1) begin
            return SEL_WR1;
        end
        return SEL_ARRAY;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// One pending bit per register for hazard detection.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (clears all bits)
//   wr0_en/wr0_addr : write port 0 strobe and address (already gated to RUN)
//   wr1_en/wr1_addr : write port 1 strobe and address (already gated to RUN)
//   issue_en/issue_addr : marks a destination register as awaiting writeback
//   rd_addr         : NUM_RD packed lookup addresses
//   rd_pending      : per-port pending flag, masked by a same-cycle write
module regfile_scoreboard #(
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_pending
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pending_reg;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_bit
            assign set_vec[gi] = issue_en && (issue_addr == ADDR_W'(gi));
            assign clr_vec[gi] = (wr0_en && (wr0_addr == ADDR_W'(gi)))
                              || (wr1_en && (wr1_addr == ADDR_W'(gi)));
        end
    endgenerate

    // Set is applied after clear: an issue in the same cycle as a writeback
    // belongs to a newer producer, so the register stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= (pending_reg & ~clr_vec) | set_vec;
        end
    end

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_lookup
            logic [ADDR_W-1:0] addr;
            logic              wr_hit;
            assign addr   = rd_addr[gi*ADDR_W +: ADDR_W];
            assign wr_hit = (wr0_en && (wr0_addr == addr)) || (wr1_en && (wr1_addr == addr));
            // A writeback landing this cycle resolves the hazard for the reader,
            // since the value is forwarded on the bypass path.
            assign rd_pending[gi] = pending_reg[addr] & ~wr_hit;
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised multi-port register file: NUM_RD combinational read ports,
// two write ports with write-to-read bypass, a pending scoreboard, and a
// sequential init engine that fills the array after reset.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   rd_addr / rd_data   : packed read addresses / data, port k at slice k
//   rd_pending          : port k's register awaits writeback
//   wr0_*               : write port 0 (ALU), highest priority
//   wr1_*               : write port 1 (memory)
//   issue_en/issue_addr : mark a destination register pending
//   init_busy           : init sequence running; writes and issues dropped
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int NUM_RD    = 2,
    parameter int INIT_MODE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic              busy_reg;

    logic              run;
    logic              wr0_ok;
    logic              wr1_ok;
    logic              issue_ok;
    logic [DATA_W-1:0] init_val;
    logic [NUM_RD-1:0] pend_raw;

    // Init sequencer: one array entry per edge; the edge that writes the last
    // entry moves to RUN. The counter holds there rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
        end else begin
            case (state_reg)
                INIT: begin
                    if (cnt_reg == ADDR_W'(DEPTH - 1)) begin
                        state_reg <= RUN;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= RUN;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign init_busy = busy_reg;
    assign run       = (state_reg == RUN);
    assign wr0_ok    = wr0_en && run;
    assign wr1_ok    = wr1_en && run;
    assign issue_ok  = issue_en && run;
    assign init_val  = (INIT_MODE == INIT_INDEX) ? DATA_W'(cnt_reg) : '0;

    // Array has no reset; contents are rebuilt by the init sequencer.
    // Port 1 is written first so that port 0 overrides it on an address tie.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[cnt_reg] <= init_val;
        end else begin
            if (wr1_ok) begin
                mem[wr1_addr] <= wr1_data;
            end
            if (wr0_ok) begin
                mem[wr0_addr] <= wr0_data;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              hit0;
            logic              hit1;
            logic [DATA_W-1:0] val;

            assign addr = rd_addr[gi*ADDR_W +: ADDR_W];
            assign hit0 = wr0_ok && (wr0_addr == addr);
            assign hit1 = wr1_ok && (wr1_addr == addr);

            always_comb begin
                val = mem[addr];
                case (bypass_sel(hit0, hit1))
                    SEL_WR0:  val = wr0_data;
                    SEL_WR1:  val = wr1_data;
                    default:  val = mem[addr];
                endcase
            end

            // Reads return zero until the array is fully initialised.
            assign rd_data[gi*DATA_W +: DATA_W] = run ? val : '0;
            assign rd_pending[gi]               = run & pend_raw[gi];
        end
    endgenerate

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .wr0_en     (wr0_ok),
        .wr0_addr   (wr0_addr),
        .wr1_en     (wr1_ok),
        .wr1_addr   (wr1_addr),
        .issue_en   (issue_ok),
        .issue_addr (issue_addr),
        .rd_addr    (rd_addr),
        .rd_pending (pend_raw)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Directed, table-driven bench for regfile_mp (defaults: 32-bit, 16 regs,
// 2 read ports). A second instance with INIT_MODE=0 shares all inputs and
// is used to check zero initialisation.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [63:0] rd_data_z;
    logic [1:0]  rd_pending;
    logic [1:0]  rd_pending_z;
    logic        wr0_en = 1'b0;
    logic [3:0]  wr0_addr = '0;
    logic [31:0] wr0_data = '0;
    logic        wr1_en = 1'b0;
    logic [3:0]  wr1_addr = '0;
    logic [31:0] wr1_data = '0;
    logic        issue_en = 1'b0;
    logic [3:0]  issue_addr = '0;
    logic        init_busy;
    logic        init_busy_z;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .INIT_MODE(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .init_busy(init_busy)
    );

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .INIT_MODE(0)) dut_z (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_pending(rd_pending_z),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .init_busy(init_busy_z)
    );

    typedef struct {
        logic        w0e;
        logic [3:0]  w0a;
        logic [31:0] w0d;
        logic        w1e;
        logic [3:0]  w1a;
        logic [31:0] w1d;
        logic        ie;
        logic [3:0]  ia;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic        ep0;
        logic        ep1;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        issue_en = 1'b0;
    endtask

    // Counts the init sequence from the cycle rst deasserts; busy must stay
    // high for DEPTH-1 edges and drop on edge DEPTH. Optionally fires writes
    // and an issue to r2 before edge 8, which must be dropped.
    task automatic run_init(input bit drop_test);
        for (int i = 1; i <= DEPTH; i++) begin
            if (drop_test && i == 8) begin
                wr0_en = 1'b1; wr0_addr = 4'd2; wr0_data = 32'hFF;
                wr1_en = 1'b1; wr1_addr = 4'd2; wr1_data = 32'hEE;
                issue_en = 1'b1; issue_addr = 4'd2;
                rd_addr = {4'd2, 4'd2};
                #1;
                chk("init_rd_data_zero", rd_data, 64'h0);
                chk("init_rd_pending_zero", {62'h0, rd_pending}, 64'h0);
            end
            step();
            idle_inputs();
            chk($sformatf("init_busy_edge%0d", i), {63'h0, init_busy}, {63'h0, (i < DEPTH)});
        end
    endtask

    task automatic apply_rst();
        rst = 1'b1;
        #1;
        chk("rst_busy", {63'h0, init_busy}, 64'h1);
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_rd_pending", {62'h0, rd_pending}, 64'h0);
        step();
        rst = 1'b0;
    endtask

    task automatic read_all(input bit with_zero);
        for (int r = 0; r < DEPTH; r++) begin
            rd_addr = {4'(DEPTH - 1 - r), 4'(r)};
            #1;
            chk($sformatf("readback_r%0d", r), rd_data, {32'(DEPTH - 1 - r), 32'(r)});
            if (with_zero) begin
                chk($sformatf("readback_zero_r%0d", r), rd_data_z, 64'h0);
            end
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 4'd0,  4'd15, 32'h0,        32'hF,        1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'd5,  32'hDEADBEEF, 1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 4'd5,  4'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 4'd5,  4'd4,  32'hDEADBEEF, 32'h4,        1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'd3,  32'h11,       1'b1, 4'd3, 32'h22,  1'b0, 4'd0, 4'd3,  4'd3,  32'h11,       32'h11,       1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 4'd3,  4'd5,  32'h11,       32'hDEADBEEF, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 32'h0,   1'b1, 4'd7, 4'd7,  4'd7,  32'h7,        32'h7,        1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 4'd7,  4'd6,  32'h7,        32'h6,        1'b1, 1'b0};
        vecs[7]  = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd7, 32'h55,  1'b0, 4'd0, 4'd7,  4'd7,  32'h55,       32'h55,       1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 4'd7,  4'd0,  32'h55,       32'h0,        1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'd7,  32'h66,       1'b0, 4'd0, 32'h0,   1'b1, 4'd7, 4'd7,  4'd7,  32'h66,       32'h66,       1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 4'd7,  4'd3,  32'h66,       32'h11,       1'b1, 1'b0};
        vecs[11] = '{1'b1, 4'd10, 32'hBB,       1'b1, 4'd9, 32'hAA,  1'b0, 4'd0, 4'd9,  4'd10, 32'hAA,       32'hBB,       1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 4'd10, 4'd9,  32'hBB,       32'hAA,       1'b0, 1'b0};
        vecs[13] = '{1'b1, 4'd7,  32'h77,       1'b0, 4'd0, 32'h0,   1'b1, 4'd2, 4'd7,  4'd2,  32'h77,       32'h2,        1'b0, 1'b0};
        vecs[14] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 4'd7,  4'd2,  32'h77,       32'h2,        1'b0, 1'b1};
        vecs[15] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd2, 32'h123, 1'b0, 4'd0, 4'd2,  4'd2,  32'h123,      32'h123,      1'b0, 1'b0};
        vecs[16] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 32'h0,   1'b0, 4'd0, 4'd2,  4'd7,  32'h123,      32'h77,       1'b0, 1'b0};

        // Power-up reset, then init with dropped writes at cycle 8.
        step();
        apply_rst();
        run_init(1'b1);
        read_all(1'b1);
        rd_addr = {4'd0, 4'd2};
        #1;
        chk("drop_r2_pending", {62'h0, rd_pending}, 64'h0);

        // Table-driven RUN vectors, one cycle each.
        for (int v = 0; v < 17; v++) begin
            wr0_en = vecs[v].w0e; wr0_addr = vecs[v].w0a; wr0_data = vecs[v].w0d;
            wr1_en = vecs[v].w1e; wr1_addr = vecs[v].w1a; wr1_data = vecs[v].w1d;
            issue_en = vecs[v].ie; issue_addr = vecs[v].ia;
            rd_addr = {vecs[v].ra1, vecs[v].ra0};
            #1;
            chk($sformatf("vec%0d_rd_data", v), rd_data, {vecs[v].ed1, vecs[v].ed0});
            chk($sformatf("vec%0d_rd_pending", v), {62'h0, rd_pending}, {62'h0, vecs[v].ep1, vecs[v].ep0});
            step();
            idle_inputs();
        end

        // Mid-RUN reset with a register pending and modified contents.
        issue_en = 1'b1; issue_addr = 4'd4;
        step();
        idle_inputs();
        rd_addr = {4'd4, 4'd4};
        #1;
        chk("pre_rst_pending_r4", {62'h0, rd_pending}, 64'h3);
        apply_rst();
        run_init(1'b0);
        rd_addr = {4'd3, 4'd5};
        #1;
        chk("run_rst_reinit_r5_r3", rd_data, {32'h3, 32'h5});
        rd_addr = {4'd4, 4'd4};
        #1;
        chk("run_rst_pending_r4", {62'h0, rd_pending}, 64'h0);
        chk("run_rst_reinit_r4", rd_data, {32'h4, 32'h4});

        // Mid-INIT reset at cycle 10 restarts the full sequence.
        wr0_en = 1'b1; wr0_addr = 4'd12; wr0_data = 32'hCAFE;
        step();
        idle_inputs();
        apply_rst();
        for (int i = 1; i <= 10; i++) begin
            step();
        end
        chk("mid_init_busy", {63'h0, init_busy}, 64'h1);
        apply_rst();
        run_init(1'b0);
        read_all(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
